// File: rtl/exec_cmd_pkg.sv
// Shared definitions for the exec_cmd command sequencer: opcodes, FSM states,
// register-bus widths and command-word field helpers.
package exec_cmd_pkg;

  localparam int unsigned REG_AW = 14;
  localparam int unsigned REG_DW = 32;

  localparam logic [1:0] OP_END = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_RD  = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_FETCH_LO,
    S_DATA_LO,
    S_DATA_HI,
    S_REGWR,
    S_REGRD,
    S_STORE_LO,
    S_STORE_HI,
    S_DONE
  } state_t;

  function automatic logic [1:0] cmd_op(input logic [15:0] w);
    return w[15:14];
  endfunction

  function automatic logic [REG_AW-1:0] cmd_addr(input logic [15:0] w);
    return w[REG_AW-1:0];
  endfunction

endpackage

// File: rtl/exec_cmd_if.sv
// Avalon-MM style register bus between the sequencer (master) and a CSR slave.
interface exec_cmd_if;
  import exec_cmd_pkg::*;

  logic [REG_AW-1:0] reg_addr;
  logic              reg_rd;
  logic              reg_wr;
  logic              reg_ready;
  logic [REG_DW-1:0] reg_writedata;
  logic [REG_DW-1:0] reg_readdata;

  modport master (
    output reg_addr, reg_rd, reg_wr, reg_writedata,
    input  reg_ready, reg_readdata
  );

  modport slave (
    input  reg_addr, reg_rd, reg_wr, reg_writedata,
    output reg_ready, reg_readdata
  );

endinterface

// File: rtl/exec_cmd.sv
// Command sequencer: walks a 16-bit command list in inram, issues 32-bit register
// reads/writes on the bus and stores read results as 16-bit words in outram.
module exec_cmd
  import exec_cmd_pkg::*;
#(
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  output logic [AW-1:0] inram_address,
  output logic          inram_re,
  input  logic [15:0]   inram_q,
  output logic [AW-1:0] outram_address,
  output logic          outram_we,
  output logic [15:0]   outram_d,
  exec_cmd_if.master    bus,
  input  logic          start_exec,
  output logic          busy,
  output logic          err,
  output logic [AW-1:0] out_len
);

  localparam logic [AW:0]   PTR_INC    = (AW+1)'(1);
  localparam logic [AW:0]   LEN_INC    = (AW+1)'(2);
  localparam logic [AW:0]   LEN_RD_MAX = (AW+1)'((1 << AW) - 2);
  localparam logic [AW-1:0] ADDR_INC   = AW'(1);

  state_t state_q, state_d;
  // Pointers carry one extra bit so a wrap past the last RAM word is visible.
  logic [AW:0]       iptr_q, iptr_d;
  logic [AW:0]       len_q, len_d;
  logic [REG_AW-1:0] addr_q, addr_d;
  logic [REG_DW-1:0] wdata_q, wdata_d;
  logic [REG_DW-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              rd_req, wr_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      iptr_q  <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      iptr_q  <= iptr_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    iptr_d         = iptr_q;
    len_d          = len_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    err_d          = err_q;
    inram_re       = 1'b0;
    inram_address  = '0;
    outram_we      = 1'b0;
    outram_address = '0;
    outram_d       = '0;
    rd_req         = 1'b0;
    wr_req         = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_exec) begin
          err_d   = 1'b0;
          len_d   = '0;
          iptr_d  = '0;
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH, S_FETCH_LO: begin
        if (iptr_q[AW]) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          inram_re      = 1'b1;
          inram_address = iptr_q[AW-1:0];
          iptr_d        = iptr_q + PTR_INC;
          state_d       = (state_q == S_FETCH) ? S_DECODE : S_DATA_LO;
        end
      end
      S_DECODE: begin
        addr_d = cmd_addr(inram_q);
        case (cmd_op(inram_q))
          OP_END: state_d = S_DONE;
          OP_WR:  state_d = S_FETCH_LO;
          OP_RD: begin
            if (len_q > LEN_RD_MAX) begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end else begin
              state_d = S_REGRD;
            end
          end
          default: begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        endcase
      end
      // The high data word is fetched in the same cycle the low word is captured.
      S_DATA_LO: begin
        wdata_d[15:0] = inram_q;
        if (iptr_q[AW]) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          inram_re      = 1'b1;
          inram_address = iptr_q[AW-1:0];
          iptr_d        = iptr_q + PTR_INC;
          state_d       = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        wdata_d[31:16] = inram_q;
        state_d        = S_REGWR;
      end
      S_REGWR: begin
        wr_req = 1'b1;
        if (bus.reg_ready) state_d = S_FETCH;
      end
      S_REGRD: begin
        rd_req = 1'b1;
        if (bus.reg_ready) begin
          rdata_d = bus.reg_readdata;
          state_d = S_STORE_LO;
        end
      end
      S_STORE_LO: begin
        outram_we      = 1'b1;
        outram_address = len_q[AW-1:0];
        outram_d       = rdata_q[15:0];
        state_d        = S_STORE_HI;
      end
      S_STORE_HI: begin
        outram_we      = 1'b1;
        outram_address = len_q[AW-1:0] + ADDR_INC;
        outram_d       = rdata_q[31:16];
        len_d          = len_q + LEN_INC;
        state_d        = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.reg_addr      = addr_q;
  assign bus.reg_writedata = wdata_q;
  assign bus.reg_rd        = rd_req;
  assign bus.reg_wr        = wr_req;

  assign busy    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign err     = err_q;
  // A completely full outram (2**AW words) reads back as 0 in this AW-bit field.
  assign out_len = len_q[AW-1:0];

endmodule

// File: tb/tb_exec_cmd.sv
// Self-checking bench for exec_cmd: RAM models, wait-state slave and a scoreboard
// of expected bus accesses and outram writes.
module tb_exec_cmd;

  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 1 << AW;

  typedef logic [15:0] words_t [8];
  typedef struct packed { logic wr; logic [13:0] addr; logic [31:0] data; } acc_t;
  typedef struct packed { logic [AW-1:0] addr; logic [15:0] data; } ow_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_exec = 1'b0;
  logic [AW-1:0] inram_address, outram_address, out_len;
  logic          inram_re, outram_we, busy, err;
  logic [15:0]   inram_q, outram_d;
  logic [15:0]   inram  [DEPTH];
  logic [15:0]   outram [DEPTH];

  int total = 0;
  int bad = 0;
  int rd_cnt = 0, wr_cnt = 0, we_cnt = 0, req_len = 0, last_req_len = 0;
  int unsigned wait_cfg = 0, wcnt = 0;
  logic [31:0] rd_base = '0;
  acc_t exp_acc[$];
  ow_t  exp_out[$];
  acc_t held, cur, e_acc;
  logic held_v = 1'b0;
  ow_t  e_out, got_out;
  logic req;
  logic [3*AW+67:0] all_outs;

  exec_cmd_if bus();

  exec_cmd #(.AW(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .inram_address  (inram_address),
    .inram_re       (inram_re),
    .inram_q        (inram_q),
    .outram_address (outram_address),
    .outram_we      (outram_we),
    .outram_d       (outram_d),
    .bus            (bus),
    .start_exec     (start_exec),
    .busy           (busy),
    .err            (err),
    .out_len        (out_len)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (inram_re) inram_q <= inram[inram_address];

  assign req                = bus.reg_rd | bus.reg_wr;
  assign bus.reg_ready      = req && (wcnt >= wait_cfg);
  assign bus.reg_readdata   = rd_base + {18'd0, bus.reg_addr};
  always @(posedge clk) wcnt <= (req && !bus.reg_ready) ? wcnt + 1 : 0;

  assign all_outs = {busy, err, out_len, inram_re, inram_address, outram_we, outram_address,
                     outram_d, bus.reg_rd, bus.reg_wr, bus.reg_addr, bus.reg_writedata};

  // Bus and outram monitor: stability while waiting, scoreboard on accept/write.
  always @(negedge clk) begin
    if (req) begin
      total++;
      if (bus.reg_rd && bus.reg_wr) begin
        bad++;
        $display("FAIL rd_wr_overlap got rd=%b wr=%b exp one-hot", bus.reg_rd, bus.reg_wr);
      end
      req_len++;
      cur = '{wr: bus.reg_wr, addr: bus.reg_addr, data: bus.reg_wr ? bus.reg_writedata : 32'h0};
      if (held_v) begin
        total++;
        if (cur !== held) begin
          bad++;
          $display("FAIL req_stable got=%h exp=%h", cur, held);
        end
      end
      held   = cur;
      held_v = 1'b1;
      if (bus.reg_ready) begin
        if (bus.reg_wr) wr_cnt++; else rd_cnt++;
        last_req_len = req_len;
        req_len = 0;
        held_v  = 1'b0;
        total++;
        if (exp_acc.size() == 0) begin
          bad++;
          $display("FAIL bus_access got=%h exp=none", cur);
        end else begin
          e_acc = exp_acc.pop_front();
          if (cur !== e_acc) begin
            bad++;
            $display("FAIL bus_access got=%h exp=%h", cur, e_acc);
          end
        end
      end
    end else begin
      req_len = 0;
      held_v  = 1'b0;
    end
    if (outram_we) begin
      we_cnt++;
      outram[outram_address] = outram_d;
      got_out = '{addr: outram_address, data: outram_d};
      total++;
      if (exp_out.size() == 0) begin
        bad++;
        $display("FAIL outram_write got=%h exp=none", got_out);
      end else begin
        e_out = exp_out.pop_front();
        if (got_out !== e_out) begin
          bad++;
          $display("FAIL outram_write got=%h exp=%h", got_out, e_out);
        end
      end
    end
  end

  task automatic load_list(input words_t w, input int n, input logic [15:0] fill);
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (i < n) inram[i] = w[i];
      else       inram[i] = fill;
      outram[i] = '0;
    end
  endtask

  // Pulses start_exec and waits for busy to drop; cyc = -1 on timeout.
  task automatic run_list(input int pulse_after_rd, output int cyc);
    int rd0;
    bit pulsed;
    rd0 = rd_cnt;
    pulsed = 1'b0;
    @(negedge clk); start_exec = 1'b1;
    @(negedge clk); start_exec = 1'b0;
    cyc = 0;
    while (busy && cyc < 2000) begin
      if (pulse_after_rd > 0 && !pulsed && (rd_cnt - rd0) >= pulse_after_rd) begin
        start_exec = 1'b1;
        pulsed = 1'b1;
      end else begin
        start_exec = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start_exec = 1'b0;
    if (busy) cyc = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_exec = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (all_outs !== '0) begin
      bad++;
      $display("FAIL reset_held got=%h exp=0", all_outs);
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (all_outs !== '0) begin
      bad++;
      $display("FAIL reset_release got=%h exp=0", all_outs);
    end
  endtask

  task automatic test_write(input string tag);
    words_t w;
    int cyc, wr0, we0;
    w = '{16'h4002, 16'h1234, 16'h5678, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0};
    load_list(w, 4, 16'h0000);
    wait_cfg = 0;
    exp_acc.push_back('{wr: 1'b1, addr: 14'h002, data: 32'h5678_1234});
    wr0 = wr_cnt;
    we0 = we_cnt;
    run_list(0, cyc);
    total++;
    if (cyc < 0) begin bad++; $display("FAIL %s_timeout got busy=%b exp 0", tag, busy); end
    total++;
    if (wr_cnt - wr0 != 1) begin bad++; $display("FAIL %s_wr_count got=%0d exp=1", tag, wr_cnt - wr0); end
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL %s_err got=%b exp=0", tag, err); end
    total++;
    if (out_len !== '0) begin bad++; $display("FAIL %s_out_len got=%0d exp=0", tag, out_len); end
    total++;
    if (we_cnt != we0) begin bad++; $display("FAIL %s_no_store got=%0d exp=0", tag, we_cnt - we0); end
    total++;
    if (exp_acc.size() != 0) begin
      bad++;
      $display("FAIL %s_pending got=%0d exp=0", tag, exp_acc.size());
      exp_acc.delete();
    end
  endtask

  task automatic test_read(input int unsigned ws, input string tag);
    words_t w;
    int cyc, rd0;
    w = '{16'h8003, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    load_list(w, 2, 16'h0000);
    wait_cfg = ws;
    rd_base = 32'hDEAD_BEEF - 32'd3;
    exp_acc.push_back('{wr: 1'b0, addr: 14'h003, data: 32'h0});
    exp_out.push_back('{addr: AW'(0), data: 16'hBEEF});
    exp_out.push_back('{addr: AW'(1), data: 16'hDEAD});
    rd0 = rd_cnt;
    run_list(0, cyc);
    total++;
    if (cyc < 0) begin bad++; $display("FAIL %s_timeout got busy=%b exp 0", tag, busy); end
    total++;
    if (rd_cnt - rd0 != 1) begin bad++; $display("FAIL %s_rd_count got=%0d exp=1", tag, rd_cnt - rd0); end
    total++;
    if (last_req_len != int'(ws) + 1) begin
      bad++;
      $display("FAIL %s_req_cycles got=%0d exp=%0d", tag, last_req_len, ws + 1);
    end
    total++;
    if ({outram[1], outram[0]} !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL %s_outram got=%h exp=deadbeef", tag, {outram[1], outram[0]});
    end
    total++;
    if (out_len !== AW'(2)) begin bad++; $display("FAIL %s_out_len got=%0d exp=2", tag, out_len); end
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL %s_err got=%b exp=0", tag, err); end
    total++;
    if (exp_acc.size() + exp_out.size() != 0) begin
      bad++;
      $display("FAIL %s_pending got=%0d exp=0", tag, exp_acc.size() + exp_out.size());
      exp_acc.delete(); exp_out.delete();
    end
  endtask

  task automatic test_back_to_back(input int unsigned ws, input int pulse, input string tag);
    words_t w;
    int cyc;
    w = '{16'h4010, 16'h5A5A, 16'hA5A5, 16'h8011, 16'h8012, 16'h0000, 16'h0, 16'h0};
    load_list(w, 6, 16'h0000);
    wait_cfg = ws;
    rd_base = 32'h89AB_0000;
    exp_acc.push_back('{wr: 1'b1, addr: 14'h010, data: 32'hA5A5_5A5A});
    exp_acc.push_back('{wr: 1'b0, addr: 14'h011, data: 32'h0});
    exp_acc.push_back('{wr: 1'b0, addr: 14'h012, data: 32'h0});
    exp_out.push_back('{addr: AW'(0), data: 16'h0011});
    exp_out.push_back('{addr: AW'(1), data: 16'h89AB});
    exp_out.push_back('{addr: AW'(2), data: 16'h0012});
    exp_out.push_back('{addr: AW'(3), data: 16'h89AB});
    run_list(pulse, cyc);
    total++;
    if (cyc < 0) begin bad++; $display("FAIL %s_timeout got busy=%b exp 0", tag, busy); end
    total++;
    if (out_len !== AW'(4)) begin bad++; $display("FAIL %s_out_len got=%0d exp=4", tag, out_len); end
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL %s_err got=%b exp=0", tag, err); end
    total++;
    if (exp_acc.size() + exp_out.size() != 0) begin
      bad++;
      $display("FAIL %s_pending got=%0d exp=0", tag, exp_acc.size() + exp_out.size());
      exp_acc.delete(); exp_out.delete();
    end
  endtask

  task automatic test_illegal();
    words_t w;
    int cyc, acc0;
    w = '{16'hC000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    load_list(w, 1, 16'h0000);
    acc0 = rd_cnt + wr_cnt;
    run_list(0, cyc);
    total++;
    if (cyc < 0 || busy !== 1'b0) begin bad++; $display("FAIL illegal_busy got=%b exp=0", busy); end
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL illegal_err got=%b exp=1", err); end
    total++;
    if (rd_cnt + wr_cnt != acc0) begin
      bad++;
      $display("FAIL illegal_no_access got=%0d exp=0", rd_cnt + wr_cnt - acc0);
    end
    total++;
    if (out_len !== '0) begin bad++; $display("FAIL illegal_out_len got=%0d exp=0", out_len); end
  endtask

  task automatic test_wrap_read();
    words_t w;
    int cyc, we0;
    w = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    load_list(w, 0, 16'h8001);
    wait_cfg = 1;
    rd_base = 32'h1000_2000;
    for (int i = 0; i < int'(DEPTH) / 2; i++) begin
      exp_acc.push_back('{wr: 1'b0, addr: 14'h001, data: 32'h0});
      exp_out.push_back('{addr: AW'(2 * i),     data: 16'h2001});
      exp_out.push_back('{addr: AW'(2 * i + 1), data: 16'h1000});
    end
    we0 = we_cnt;
    run_list(0, cyc);
    total++;
    if (cyc < 0) begin bad++; $display("FAIL wrap_read_timeout got busy=%b exp 0", busy); end
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL wrap_read_err got=%b exp=1", err); end
    total++;
    if (we_cnt - we0 != int'(DEPTH)) begin
      bad++;
      $display("FAIL wrap_read_words got=%0d exp=%0d", we_cnt - we0, DEPTH);
    end
    total++;
    if (exp_acc.size() + exp_out.size() != 0) begin
      bad++;
      $display("FAIL wrap_read_pending got=%0d exp=0", exp_acc.size() + exp_out.size());
      exp_acc.delete(); exp_out.delete();
    end
  endtask

  task automatic test_wrap_inram();
    words_t w;
    int cyc, wr0;
    w = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    load_list(w, 0, 16'h4001);
    wait_cfg = 0;
    for (int i = 0; i < 5; i++) exp_acc.push_back('{wr: 1'b1, addr: 14'h001, data: 32'h4001_4001});
    wr0 = wr_cnt;
    run_list(0, cyc);
    total++;
    if (cyc < 0) begin bad++; $display("FAIL wrap_inram_timeout got busy=%b exp 0", busy); end
    total++;
    if (err !== 1'b1) begin bad++; $display("FAIL wrap_inram_err got=%b exp=1", err); end
    total++;
    if (wr_cnt - wr0 != 5) begin bad++; $display("FAIL wrap_inram_writes got=%0d exp=5", wr_cnt - wr0); end
    total++;
    if (exp_acc.size() != 0) begin
      bad++;
      $display("FAIL wrap_inram_pending got=%0d exp=0", exp_acc.size());
      exp_acc.delete();
    end
  endtask

  task automatic test_abort_restart();
    words_t w;
    int n, strobes;
    w = '{16'h8003, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    load_list(w, 2, 16'h0000);
    wait_cfg = 20;
    rd_base = 32'h1111_2222;
    @(negedge clk); start_exec = 1'b1;
    @(negedge clk); start_exec = 1'b0;
    n = 0;
    while (!bus.reg_rd && n < 50) begin @(negedge clk); n++; end
    total++;
    if (bus.reg_rd !== 1'b1) begin bad++; $display("FAIL abort_rd_seen got=%b exp=1", bus.reg_rd); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (all_outs !== '0) begin bad++; $display("FAIL abort_outputs got=%h exp=0", all_outs); end
    strobes = 0;
    repeat (6) begin
      @(negedge clk);
      if (inram_re || outram_we || bus.reg_rd || bus.reg_wr || busy) strobes++;
    end
    total++;
    if (strobes != 0) begin bad++; $display("FAIL abort_quiet got=%0d exp=0", strobes); end
    test_write("rerun");
    test_back_to_back(0, 1, "start_busy");
  endtask

  initial begin
    test_reset();
    test_write("write");
    test_read(0, "read");
    test_read(5, "wait");
    test_back_to_back(2, 0, "b2b");
    test_illegal();
    test_write("err_clear");
    test_wrap_read();
    test_wrap_inram();
    test_abort_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
